// File: rtl/rv32_pkg.sv
// Shared RV32 decode types: opcodes, ALU/muldiv operations and the decoded bundle.
package rv32_pkg;

    typedef enum logic [6:0] {
        OP_LOAD     = 7'b0000011,
        OP_MISC_MEM = 7'b0001111,
        OP_OP_IMM   = 7'b0010011,
        OP_AUIPC    = 7'b0010111,
        OP_STORE    = 7'b0100011,
        OP_OP       = 7'b0110011,
        OP_LUI      = 7'b0110111,
        OP_BRANCH   = 7'b1100011,
        OP_JALR     = 7'b1100111,
        OP_JAL      = 7'b1101111,
        OP_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // Encoding equals funct3 of the M-extension instructions.
    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } muldiv_op_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_e     alu_op;
        muldiv_op_e  muldiv_op;
        logic [2:0]  funct3;      // load/store width, branch condition
        logic        reg_write;
        logic        alu_src_imm; // operand B is imm
        logic        alu_src_pc;  // operand A is PC
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        is_muldiv;
        logic        is_fence;
        logic        is_system;
    } decoded_instr_t;

    // One pipeline slot: what the stage presents to execute.
    typedef struct packed {
        decoded_instr_t dec;
        logic [31:0]    pc;
        logic           illegal;
    } stage_slot_t;

    // Register/immediate ALU ops share the funct3 mapping (shift direction aside).
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32_decode_core.sv
// Combinational RV32I(+M) decoder with full legality checking.
module rv32_decode_core
    import rv32_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0]    instr_raw_i,
    output decoded_instr_t decoded_o,
    output logic           illegal_o
);

    logic [6:0] f7;
    logic [2:0] f3;
    assign f7 = instr_raw_i[31:25];
    assign f3 = instr_raw_i[14:12];

    // Decode fields per opcode; illegal encodings keep only register indices.
    always_comb begin
        decoded_instr_t d;
        logic           ill;
        d            = '0;
        ill          = 1'b0;
        d.rs1        = instr_raw_i[19:15];
        d.rs2        = instr_raw_i[24:20];
        d.rd         = instr_raw_i[11:7];
        d.funct3     = f3;
        case (instr_raw_i[6:0])
            OP_OP: begin
                d.reg_write = 1'b1;
                if (f7 == 7'b0000000) begin
                    d.alu_op = alu_from_f3(f3);
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d.alu_op = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d.alu_op = ALU_SRA;
                end else if (ENABLE_M && f7 == 7'b0000001) begin
                    d.is_muldiv = 1'b1;
                    d.muldiv_op = muldiv_op_e'(f3);
                end else begin
                    ill = 1'b1;
                end
            end
            OP_OP_IMM: begin
                d.reg_write   = 1'b1;
                d.alu_src_imm = 1'b1;
                d.imm         = {{20{instr_raw_i[31]}}, instr_raw_i[31:20]};
                d.alu_op      = alu_from_f3(f3);
                if (f3 == 3'b001 && f7 != 7'b0000000) ill = 1'b1;
                if (f3 == 3'b101) begin
                    if (f7 == 7'b0100000)      d.alu_op = ALU_SRA;
                    else if (f7 != 7'b0000000) ill = 1'b1;
                end
            end
            OP_LOAD: begin
                d.reg_write   = 1'b1;
                d.mem_read    = 1'b1;
                d.alu_src_imm = 1'b1;
                d.imm         = {{20{instr_raw_i[31]}}, instr_raw_i[31:20]};
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
            end
            OP_STORE: begin
                d.mem_write   = 1'b1;
                d.alu_src_imm = 1'b1;
                d.imm         = {{20{instr_raw_i[31]}}, instr_raw_i[31:25], instr_raw_i[11:7]};
                if (f3 > 3'b010) ill = 1'b1;
            end
            OP_BRANCH: begin
                d.branch = 1'b1;
                d.alu_op = ALU_SUB;
                d.imm    = {{19{instr_raw_i[31]}}, instr_raw_i[31], instr_raw_i[7],
                            instr_raw_i[30:25], instr_raw_i[11:8], 1'b0};
                if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
            end
            OP_JAL: begin
                d.reg_write  = 1'b1;
                d.jump       = 1'b1;
                d.alu_src_pc = 1'b1;
                d.imm        = {{11{instr_raw_i[31]}}, instr_raw_i[31], instr_raw_i[19:12],
                                instr_raw_i[20], instr_raw_i[30:21], 1'b0};
            end
            OP_JALR: begin
                d.reg_write   = 1'b1;
                d.jump        = 1'b1;
                d.alu_src_imm = 1'b1;
                d.imm         = {{20{instr_raw_i[31]}}, instr_raw_i[31:20]};
                if (f3 != 3'b000) ill = 1'b1;
            end
            OP_LUI: begin
                // x0 + imm: rs1 forced to zero so the adder path serves LUI.
                d.rs1         = 5'd0;
                d.reg_write   = 1'b1;
                d.alu_src_imm = 1'b1;
                d.imm         = {instr_raw_i[31:12], 12'b0};
            end
            OP_AUIPC: begin
                d.reg_write   = 1'b1;
                d.alu_src_imm = 1'b1;
                d.alu_src_pc  = 1'b1;
                d.imm         = {instr_raw_i[31:12], 12'b0};
            end
            OP_MISC_MEM: d.is_fence  = 1'b1;
            OP_SYSTEM:   d.is_system = 1'b1;
            default:     ill = 1'b1;
        endcase
        if (instr_raw_i[1:0] != 2'b11) ill = 1'b1;
        if (ill) begin
            d        = '0;
            d.rs1    = instr_raw_i[19:15];
            d.rs2    = instr_raw_i[24:20];
            d.rd     = instr_raw_i[11:7];
        end
        decoded_o = d;
        illegal_o = ill;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: main output slot plus one skid slot, flushable.
module decode_stage
    import rv32_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_raw_i,
    input  logic [31:0]      pc_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output decoded_instr_t   decoded_instr_o,
    output logic [31:0]      pc_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_count_o
);

    stage_slot_t      main_q, main_d, skid_q, skid_d, in_slot;
    logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    decoded_instr_t   core_dec;
    logic             core_ill;
    logic             in_hs, out_hs;

    rv32_decode_core #(.ENABLE_M(ENABLE_M)) u_core (
        .instr_raw_i (instr_raw_i),
        .decoded_o   (core_dec),
        .illegal_o   (core_ill)
    );

    // Ready depends only on held state, so back-pressure never ripples upstream combinationally.
    assign in_ready_o = !skid_vld_q && !rst_i;
    assign in_hs      = in_valid_i && in_ready_o;
    assign out_hs     = main_vld_q && out_ready_i;

    // Bundle the freshly decoded instruction with its PC.
    always_comb begin
        in_slot.dec     = core_dec;
        in_slot.pc      = pc_i;
        in_slot.illegal = core_ill;
    end

    // Slot movement: skid drains into main first, keeping FIFO order.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        cnt_d      = cnt_q + CNT_W'(out_hs);
        if (flush_i) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_hs || !main_vld_q) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = in_hs;
                if (in_hs) main_d = in_slot;
            end
        end else if (in_hs) begin
            skid_d     = in_slot;
            skid_vld_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid_o     = main_vld_q;
    assign decoded_instr_o = main_q.dec;
    assign pc_o            = main_q.pc;
    assign illegal_o       = main_q.illegal;
    assign instr_count_o   = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one DUT without M (CNT_W=4), one with M (CNT_W=32).
module tb_decode_stage;
    import rv32_pkg::*;

    logic           clk = 1'b0;
    logic           rst, in_valid, flush, out_ready;
    logic [31:0]    raw, pc;
    logic           in_ready, out_valid, illegal;
    logic           in_ready_m, out_valid_m, illegal_m;
    decoded_instr_t dec, dec_m;
    logic [31:0]    pc_out, pc_out_m;
    logic [3:0]     cnt;
    logic [31:0]    cnt_m;
    int             nvec = 0;
    int             nerr = 0;

    always #5 clk = ~clk;

    decode_stage #(.ENABLE_M(1'b0), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .instr_raw_i(raw), .pc_i(pc), .flush_i(flush), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .decoded_instr_o(dec), .pc_o(pc_out),
        .illegal_o(illegal), .instr_count_o(cnt)
    );

    decode_stage #(.ENABLE_M(1'b1), .CNT_W(32)) dut_m (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_m),
        .instr_raw_i(raw), .pc_i(pc), .flush_i(flush), .out_valid_o(out_valid_m),
        .out_ready_i(out_ready), .decoded_instr_o(dec_m), .pc_o(pc_out_m),
        .illegal_o(illegal_m), .instr_count_o(cnt_m)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi_x1(input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        raw = 32'h0; pc = 32'h0;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
        raw = addi_x1(12'd5); pc = 32'h40;
        tick(); tick();
        nvec++; if (out_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", out_valid); nerr++; end
        nvec++; if (in_ready !== 1'b0) begin $display("FAIL reset_in_ready got %b want 0", in_ready); nerr++; end
        nvec++; if (cnt !== 4'd0) begin $display("FAIL reset_cnt got %0d want 0", cnt); nerr++; end
        nvec++; if ({dec, pc_out, illegal} !== '0) begin $display("FAIL reset_data got %h want 0", {dec, pc_out, illegal}); nerr++; end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        nvec++; if (in_ready !== 1'b1) begin $display("FAIL post_reset_in_ready got %b want 1", in_ready); nerr++; end
    endtask

    task automatic test_addi();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; raw = 32'h00500093; pc = 32'h100;
        tick();
        in_valid = 1'b0;
        nvec++; if (out_valid !== 1'b1) begin $display("FAIL addi_valid got %b want 1", out_valid); nerr++; end
        nvec++; if (dec.alu_op !== ALU_ADD) begin $display("FAIL addi_alu got %0d want %0d", dec.alu_op, ALU_ADD); nerr++; end
        nvec++; if (dec.imm !== 32'd5) begin $display("FAIL addi_imm got %h want 5", dec.imm); nerr++; end
        nvec++; if (dec.rd !== 5'd1 || dec.reg_write !== 1'b1 || dec.alu_src_imm !== 1'b1) begin
            $display("FAIL addi_ctrl got rd=%0d rw=%b imm_src=%b want rd=1 rw=1 imm_src=1", dec.rd, dec.reg_write, dec.alu_src_imm); nerr++; end
        nvec++; if (illegal !== 1'b0) begin $display("FAIL addi_illegal got %b want 0", illegal); nerr++; end
        nvec++; if (pc_out !== 32'h100) begin $display("FAIL addi_pc got %h want 100", pc_out); nerr++; end
        tick();
        nvec++; if (out_valid !== 1'b0 || cnt !== 4'd1) begin
            $display("FAIL addi_drain got valid=%b cnt=%0d want valid=0 cnt=1", out_valid, cnt); nerr++; end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; pc = 32'h0; raw = addi_x1(12'h0);
        tick();
        nvec++; if (in_ready !== 1'b1 || pc_out !== 32'h0) begin
            $display("FAIL bp_first got ready=%b pc=%h want ready=1 pc=0", in_ready, pc_out); nerr++; end
        pc = 32'h4; raw = addi_x1(12'h4);
        tick();
        nvec++; if (in_ready !== 1'b0) begin $display("FAIL bp_ready_drop got %b want 0", in_ready); nerr++; end
        pc = 32'h8; raw = addi_x1(12'h8);
        tick();
        nvec++; if (out_valid !== 1'b1 || pc_out !== 32'h0 || dec.imm !== 32'h0 || in_ready !== 1'b0) begin
            $display("FAIL bp_stable got valid=%b pc=%h imm=%h ready=%b want 1/0/0/0", out_valid, pc_out, dec.imm, in_ready); nerr++; end
        out_ready = 1'b1;
        tick();
        nvec++; if (pc_out !== 32'h4 || dec.imm !== 32'h4 || in_ready !== 1'b1) begin
            $display("FAIL bp_second got pc=%h imm=%h ready=%b want 4/4/1", pc_out, dec.imm, in_ready); nerr++; end
        tick();
        in_valid = 1'b0;
        nvec++; if (pc_out !== 32'h8 || dec.imm !== 32'h8 || out_valid !== 1'b1) begin
            $display("FAIL bp_third got pc=%h imm=%h valid=%b want 8/8/1", pc_out, dec.imm, out_valid); nerr++; end
        tick();
        nvec++; if (out_valid !== 1'b0 || cnt !== 4'd3) begin
            $display("FAIL bp_drain got valid=%b cnt=%0d want valid=0 cnt=3", out_valid, cnt); nerr++; end
    endtask

    task automatic test_muldiv();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; raw = 32'h022081B3; pc = 32'h20;
        tick();
        in_valid = 1'b0;
        nvec++; if (illegal !== 1'b1 || dec.reg_write !== 1'b0 || dec.is_muldiv !== 1'b0 || dec.rd !== 5'd3) begin
            $display("FAIL mul_noM got ill=%b rw=%b md=%b rd=%0d want 1/0/0/3", illegal, dec.reg_write, dec.is_muldiv, dec.rd); nerr++; end
        nvec++; if (illegal_m !== 1'b0 || dec_m.is_muldiv !== 1'b1 || dec_m.muldiv_op !== MD_MUL
                    || dec_m.rd !== 5'd3 || dec_m.reg_write !== 1'b1) begin
            $display("FAIL mul_M got ill=%b md=%b op=%0d rd=%0d rw=%b want 0/1/0/3/1",
                     illegal_m, dec_m.is_muldiv, dec_m.muldiv_op, dec_m.rd, dec_m.reg_write); nerr++; end
        in_valid = 1'b1; raw = 32'h0220F1B3; // REMU x3,x1,x2
        tick();
        in_valid = 1'b0;
        nvec++; if (illegal_m !== 1'b0 || dec_m.muldiv_op !== MD_REMU || illegal !== 1'b1) begin
            $display("FAIL remu got ill_m=%b op=%0d ill=%b want 0/7/1", illegal_m, dec_m.muldiv_op, illegal); nerr++; end
    endtask

    // raw word, expected illegal, expected imm (only checked when legal), expected ctrl {rw,mr,mw,br,jmp}
    task automatic test_illegal();
        logic [31:0] t_raw [10] = '{32'hFFFFFFFF, 32'h0000F003, 32'h00812283, 32'h0020B023,
                                    32'h0020A1A3, 32'h0020A063, 32'hFE000EE3, 32'hFFF00093,
                                    32'h40209093, 32'h0000F0E7};
        logic        t_ill [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] t_imm [10] = '{32'h0, 32'h0, 32'h8, 32'h0, 32'h3, 32'h0, 32'hFFFFFFFC,
                                    32'hFFFFFFFF, 32'h0, 32'h0};
        logic [4:0]  t_ctl [10] = '{5'b00000, 5'b00000, 5'b11000, 5'b00000, 5'b00100, 5'b00000,
                                    5'b00010, 5'b10000, 5'b00000, 5'b00000};
        logic [4:0]  got;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; raw = t_raw[i]; pc = 32'h200 + 32'(i * 4);
            tick();
            got = {dec.reg_write, dec.mem_read, dec.mem_write, dec.branch, dec.jump};
            nvec++; if (illegal !== t_ill[i] || got !== t_ctl[i] || (!t_ill[i] && dec.imm !== t_imm[i])) begin
                $display("FAIL decode_%h got ill=%b ctl=%b imm=%h want ill=%b ctl=%b imm=%h",
                         t_raw[i], illegal, got, dec.imm, t_ill[i], t_ctl[i], t_imm[i]); nerr++; end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        pc = 32'h30; raw = addi_x1(12'h30); tick();
        pc = 32'h34; raw = addi_x1(12'h34); tick();
        flush = 1'b1; out_ready = 1'b1; pc = 32'h38; raw = addi_x1(12'h38);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL flush_empty got valid=%b ready=%b want 0/1", out_valid, in_ready); nerr++; end
        nvec++; if (cnt !== 4'd1) begin $display("FAIL flush_cnt got %0d want 1", cnt); nerr++; end
        tick();
        nvec++; if (out_valid !== 1'b0) begin $display("FAIL flush_dropped got valid=%b pc=%h want valid=0", out_valid, pc_out); nerr++; end
        in_valid = 1'b1; pc = 32'h3C; raw = addi_x1(12'h3C);
        tick();
        in_valid = 1'b0;
        nvec++; if (out_valid !== 1'b1 || pc_out !== 32'h3C) begin
            $display("FAIL flush_resume got valid=%b pc=%h want 1/3c", out_valid, pc_out); nerr++; end
    endtask

    task automatic test_count_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; pc = 32'(i * 4); raw = addi_x1(12'(i));
            tick();
            nvec++; if (out_valid !== 1'b1 || pc_out !== 32'(i * 4)) begin
                $display("FAIL stream_%0d got valid=%b pc=%h want 1/%h", i, out_valid, pc_out, i * 4); nerr++; end
        end
        in_valid = 1'b0;
        tick();
        nvec++; if (cnt !== 4'd1 || cnt_m !== 32'd17 || out_valid !== 1'b0) begin
            $display("FAIL count_wrap got cnt=%0d cnt_m=%0d valid=%b want 1/17/0", cnt, cnt_m, out_valid); nerr++; end
        in_valid = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        nvec++; if (cnt !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL mid_reset got cnt=%0d valid=%b ready=%b want 0/0/0", cnt, out_valid, in_ready); nerr++; end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        nvec++; if (in_ready !== 1'b1) begin $display("FAIL mid_reset_ready got %b want 1", in_ready); nerr++; end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_muldiv();
        test_illegal();
        test_flush();
        test_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
